// File: rtl/coin_collector.sv
// coin_collector: credit accumulation front end handing one transaction to the vending FSM.
// Define COIN_TIMEOUT_EN to auto-refund after TIMEOUT_CYCLES idle cycles in COLLECT.
module coin_collector #(
    parameter int MAX_CREDIT     = 100,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_in,
    input  logic [1:0] coin_type,
    input  logic       sel_valid,
    input  logic [3:0] sel_id,
    input  logic       cancel,
    input  logic       done_i,
    output logic       coin,
    output logic [6:0] value_coin,
    output logic [3:0] id_item,
    output logic [6:0] credit_o,
    output logic       coin_reject,
    output logic       sel_err,
    output logic       refund,
    output logic [6:0] refund_value,
    output logic       busy,
    output logic [2:0] state_o
);
    typedef enum logic [2:0] {IDLE = 3'd0, COLLECT = 3'd1, DISPENSE = 3'd2, WAIT_DONE = 3'd3, REFUND = 3'd4} state_t;
    state_t     state_q, state_d;
    logic [6:0] credit_q, credit_d, value_q, value_d, refval_q, refval_d;
    logic [3:0] id_q, id_d;
    logic       coin_q, coin_d, rej_q, rej_d, selerr_q, selerr_d, refund_q, refund_d, busy_q, busy_d;
    logic [7:0] val, sum;
    logic       accept, sel_ok, tmo;
    // Sum is one bit wider than credit so an overflowing coin is rejected rather than wrapped
    assign val    = coin_type == 2'd0 ? 8'd5 : coin_type == 2'd1 ? 8'd10 : coin_type == 2'd2 ? 8'd20 : 8'd50;
    assign sum    = {1'b0, credit_q} + val;
    assign accept = coin_in && (state_q == IDLE || state_q == COLLECT) && !cancel && !sel_valid && sum <= 8'(MAX_CREDIT);
    assign sel_ok = sel_id >= 4'd1 && sel_id <= 4'd10;
`ifdef COIN_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cnt_top;
    assign cnt_top = cnt_q == CW'(TIMEOUT_CYCLES - 1);
    assign tmo     = state_q == COLLECT && !cancel && !sel_valid && !accept && cnt_top;
    assign cnt_d   = (state_q != COLLECT || accept) ? '0 : cnt_top ? cnt_q : cnt_q + 1'b1;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign tmo = 1'b0;
`endif
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        value_d  = value_q;
        id_d     = id_q;
        selerr_d = 1'b0;
        case (state_q)
            IDLE: begin
                selerr_d = sel_valid;
                if (accept) begin
                    credit_d = sum[6:0];
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                if (cancel || tmo) state_d = REFUND;
                else if (sel_valid && sel_ok) begin
                    id_d    = sel_id;
                    value_d = credit_q;
                    state_d = DISPENSE;
                end else if (sel_valid) selerr_d = 1'b1;
                else if (accept) credit_d = sum[6:0];
            end
            DISPENSE: state_d = WAIT_DONE;
            WAIT_DONE: begin
                selerr_d = sel_valid;
                if (done_i) begin
                    state_d  = IDLE;
                    credit_d = '0;
                    value_d  = '0;
                    id_d     = '0;
                end
            end
            REFUND: begin
                state_d  = IDLE;
                credit_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    // Output pulses are derived from the next state so they appear in the state's own cycle
    assign coin_d   = state_d == DISPENSE;
    assign busy_d   = state_d == DISPENSE || state_d == WAIT_DONE;
    assign refund_d = state_d == REFUND;
    assign refval_d = refund_d ? credit_q : '0;
    assign rej_d    = coin_in && !accept;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            value_q  <= '0;
            id_q     <= '0;
            refval_q <= '0;
            coin_q   <= 1'b0;
            rej_q    <= 1'b0;
            selerr_q <= 1'b0;
            refund_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            value_q  <= value_d;
            id_q     <= id_d;
            refval_q <= refval_d;
            coin_q   <= coin_d;
            rej_q    <= rej_d;
            selerr_q <= selerr_d;
            refund_q <= refund_d;
            busy_q   <= busy_d;
        end
    end
    assign coin         = coin_q;
    assign value_coin   = value_q;
    assign id_item      = id_q;
    assign credit_o     = credit_q;
    assign coin_reject  = rej_q;
    assign sel_err      = selerr_q;
    assign refund       = refund_q;
    assign refund_value = refval_q;
    assign busy         = busy_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_coin_collector.sv
// tb_coin_collector: scenario tasks plus a scoreboard for coin and refund pulses.
module tb_coin_collector;
    logic       clk = 1'b0, rst = 1'b1;
    logic       coin_in = 1'b0, sel_valid = 1'b0, cancel = 1'b0, done_i = 1'b0;
    logic [1:0] coin_type = '0;
    logic [3:0] sel_id = '0;
    logic       coin, coin_reject, sel_err, refund, busy;
    logic [6:0] value_coin, credit_o, refund_value;
    logic [3:0] id_item;
    logic [2:0] state_o;
    int         n_tests = 0, n_fail = 0;
    logic [10:0] q_coin[$];
    logic [6:0]  q_ref[$];

    coin_collector #(.MAX_CREDIT(100), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .coin_in(coin_in), .coin_type(coin_type), .sel_valid(sel_valid),
        .sel_id(sel_id), .cancel(cancel), .done_i(done_i), .coin(coin), .value_coin(value_coin),
        .id_item(id_item), .credit_o(credit_o), .coin_reject(coin_reject), .sel_err(sel_err),
        .refund(refund), .refund_value(refund_value), .busy(busy), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Scoreboard: every coin/refund pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (coin) begin
            n_tests++;
            if (q_coin.size() == 0) begin
                n_fail++;
                $display("FAIL coin_pulse: unexpected pulse value=%0d id=%0d", value_coin, id_item);
            end else begin
                logic [10:0] e;
                e = q_coin.pop_front();
                if ({value_coin, id_item} !== e) begin
                    n_fail++;
                    $display("FAIL coin_pulse: got value=%0d id=%0d want value=%0d id=%0d", value_coin, id_item, e[10:4], e[3:0]);
                end
            end
        end
        if (refund) begin
            n_tests++;
            if (q_ref.size() == 0) begin
                n_fail++;
                $display("FAIL refund_pulse: unexpected pulse value=%0d", refund_value);
            end else begin
                logic [6:0] r;
                r = q_ref.pop_front();
                if (refund_value !== r) begin
                    n_fail++;
                    $display("FAIL refund_pulse: got %0d want %0d", refund_value, r);
                end
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic put_coin(input logic [1:0] t);
        coin_in = 1'b1; coin_type = t; tick(); coin_in = 1'b0;
    endtask
    task automatic select(input logic [3:0] id);
        sel_valid = 1'b1; sel_id = id; tick(); sel_valid = 1'b0;
    endtask
    task automatic do_cancel();
        cancel = 1'b1; tick(); cancel = 1'b0;
    endtask
    task automatic do_done();
        done_i = 1'b1; tick(); done_i = 1'b0;
    endtask

    task automatic test_reset();
        tick(2);
        n_tests++;
        if ({coin, value_coin, id_item, credit_o, coin_reject, sel_err, refund, refund_value, busy, state_o} !== '0) begin
            n_fail++;
            $display("FAIL reset: outputs not zero state=%0d credit=%0d", state_o, credit_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_purchase();
        put_coin(2'd2);
        n_tests++; if (credit_o !== 7'd20) begin n_fail++; $display("FAIL credit20: got %0d want 20", credit_o); end
        put_coin(2'd1);
        n_tests++; if (credit_o !== 7'd30) begin n_fail++; $display("FAIL credit30: got %0d want 30", credit_o); end
        put_coin(2'd0);
        n_tests++; if (credit_o !== 7'd35) begin n_fail++; $display("FAIL credit35: got %0d want 35", credit_o); end
        q_coin.push_back({7'd35, 4'd3});
        select(4'd3);
        n_tests++; if ({state_o, coin, busy} !== {3'd2, 2'b11}) begin n_fail++; $display("FAIL dispense: got state=%0d coin=%0d busy=%0d want 2 1 1", state_o, coin, busy); end
        tick();
        do_cancel();
        tick(3);
        n_tests++;
        if ({state_o, coin, busy, value_coin, id_item} !== {3'd3, 1'b0, 1'b1, 7'd35, 4'd3}) begin
            n_fail++;
            $display("FAIL wait_hold: got state=%0d coin=%0d busy=%0d value=%0d id=%0d want 3 0 1 35 3", state_o, coin, busy, value_coin, id_item);
        end
        do_done();
        n_tests++;
        if ({state_o, busy, credit_o, value_coin, id_item} !== '0) begin
            n_fail++;
            $display("FAIL after_done: got state=%0d busy=%0d credit=%0d value=%0d id=%0d want all 0", state_o, busy, credit_o, value_coin, id_item);
        end
    endtask

    task automatic test_max_credit();
        put_coin(2'd3);
        put_coin(2'd3);
        n_tests++; if (credit_o !== 7'd100) begin n_fail++; $display("FAIL credit100: got %0d want 100", credit_o); end
        put_coin(2'd0);
        n_tests++; if ({coin_reject, credit_o} !== {1'b1, 7'd100}) begin n_fail++; $display("FAIL over_max: got reject=%0d credit=%0d want 1 100", coin_reject, credit_o); end
        tick();
        n_tests++; if (coin_reject !== 1'b0) begin n_fail++; $display("FAIL reject_pulse_len: got %0d want 0", coin_reject); end
        q_ref.push_back(7'd100);
        do_cancel();
        tick();
        n_tests++; if ({state_o, credit_o} !== '0) begin n_fail++; $display("FAIL refund_idle: got state=%0d credit=%0d want 0 0", state_o, credit_o); end
    endtask

    task automatic test_sel_err();
        put_coin(2'd1);
        select(4'd0);
        n_tests++; if ({sel_err, state_o} !== {1'b1, 3'd1}) begin n_fail++; $display("FAIL sel_err0: got err=%0d state=%0d want 1 1", sel_err, state_o); end
        select(4'd12);
        n_tests++; if ({sel_err, credit_o} !== {1'b1, 7'd10}) begin n_fail++; $display("FAIL sel_err12: got err=%0d credit=%0d want 1 10", sel_err, credit_o); end
        q_ref.push_back(7'd10);
        do_cancel();
        n_tests++; if ({refund, state_o} !== {1'b1, 3'd4}) begin n_fail++; $display("FAIL refund_state: got refund=%0d state=%0d want 1 4", refund, state_o); end
        tick();
        n_tests++; if ({refund, state_o, credit_o} !== '0) begin n_fail++; $display("FAIL refund_end: got refund=%0d state=%0d credit=%0d want 0", refund, state_o, credit_o); end
    endtask

    task automatic test_coin_with_sel();
        put_coin(2'd1);
        q_coin.push_back({7'd10, 4'd2});
        sel_valid = 1'b1; sel_id = 4'd2; coin_in = 1'b1; coin_type = 2'd3;
        tick();
        sel_valid = 1'b0; coin_in = 1'b0;
        n_tests++; if ({coin_reject, state_o, value_coin} !== {1'b1, 3'd2, 7'd10}) begin n_fail++; $display("FAIL coin_sel_same: got reject=%0d state=%0d value=%0d want 1 2 10", coin_reject, state_o, value_coin); end
        tick();
        put_coin(2'd0);
        n_tests++; if ({coin_reject, credit_o, state_o} !== {1'b1, 7'd10, 3'd3}) begin n_fail++; $display("FAIL coin_in_wait: got reject=%0d credit=%0d state=%0d want 1 10 3", coin_reject, credit_o, state_o); end
        select(4'd5);
        n_tests++; if ({sel_err, id_item} !== {1'b1, 4'd2}) begin n_fail++; $display("FAIL sel_in_wait: got err=%0d id=%0d want 1 2", sel_err, id_item); end
        do_done();
    endtask

    task automatic test_idle_inputs();
        select(4'd4);
        n_tests++; if ({sel_err, state_o} !== {1'b1, 3'd0}) begin n_fail++; $display("FAIL idle_sel: got err=%0d state=%0d want 1 0", sel_err, state_o); end
        do_cancel();
        done_i = 1'b1; tick(); done_i = 1'b0;
        n_tests++; if ({state_o, refund, busy} !== '0) begin n_fail++; $display("FAIL idle_cancel: got state=%0d refund=%0d busy=%0d want 0", state_o, refund, busy); end
    endtask

    task automatic test_reset_mid();
        put_coin(2'd2);
        put_coin(2'd2);
        q_coin.push_back({7'd40, 4'd1});
        select(4'd1);
        tick();
        n_tests++; if ({state_o, credit_o} !== {3'd3, 7'd40}) begin n_fail++; $display("FAIL pre_reset: got state=%0d credit=%0d want 3 40", state_o, credit_o); end
        rst = 1'b1; tick(); rst = 1'b0;
        n_tests++;
        if ({coin, value_coin, id_item, credit_o, coin_reject, sel_err, refund, refund_value, busy, state_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got state=%0d credit=%0d value=%0d refund=%0d want all 0", state_o, credit_o, value_coin, refund);
        end
        tick();
    endtask

`ifdef COIN_TIMEOUT_EN
    task automatic test_timeout();
        put_coin(2'd0);
        tick(7);
        n_tests++; if ({state_o, refund} !== {3'd1, 1'b0}) begin n_fail++; $display("FAIL timeout_early: got state=%0d refund=%0d want 1 0", state_o, refund); end
        q_ref.push_back(7'd5);
        tick();
        n_tests++; if ({state_o, refund} !== {3'd4, 1'b1}) begin n_fail++; $display("FAIL timeout_fire: got state=%0d refund=%0d want 4 1", state_o, refund); end
        tick();
        put_coin(2'd0);
        tick(6);
        put_coin(2'd0);
        tick(7);
        n_tests++; if ({state_o, credit_o} !== {3'd1, 7'd10}) begin n_fail++; $display("FAIL timeout_restart: got state=%0d credit=%0d want 1 10", state_o, credit_o); end
        q_ref.push_back(7'd10);
        tick();
        n_tests++; if ({state_o, refund} !== {3'd4, 1'b1}) begin n_fail++; $display("FAIL timeout_fire2: got state=%0d refund=%0d want 4 1", state_o, refund); end
        tick();
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_purchase();
        test_max_credit();
        test_sel_err();
        test_coin_with_sel();
        test_idle_inputs();
        test_reset_mid();
`ifdef COIN_TIMEOUT_EN
        test_timeout();
`endif
        tick(2);
        n_tests++;
        if (q_coin.size() != 0 || q_ref.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d coin and %0d refund pending want 0 0", q_coin.size(), q_ref.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
